obc_challenge_sequencer: RTL and testbench

Upstream stage of the OBC health checker. It generates pseudo-random 4-bit challenges and sends them to the OBC link (I2C front-end) with a valid/ready handshake. It then waits a bounded time for the OBC's answer and hands the checker one {question, answer, timeout} record per challenge. This replaces free-running $random question generation with a deterministic, synthesizable, paced exchange.

---
 rtl/obc_chk_pkg.sv | 28 ++
 rtl/obc_challenge_sequencer_if.sv | 26 ++
 rtl/chal_lfsr.sv | 18 +
 rtl/obc_challenge_sequencer.sv | 116 +++++++++++
 tb/tb_obc_challenge_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/obc_chk_pkg.sv
// Shared types for the OBC health checker: question width, sequencer states,
// LFSR taps and the {question, answer, timeout} record handed to the checker.
package obc_chk_pkg;

    localparam int Q_W = 4;

    // x^4 + x^3 + 1: feedback is q[3]^q[2], shifted in at the LSB
    localparam logic [Q_W-1:0] LFSR_TAPS = 4'b1100;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_ANS,
        ST_REPORT,
        ST_GAP
    } chal_state_t;

    typedef struct packed {
        logic [Q_W-1:0] question;
        logic [Q_W-1:0] answer;
        logic           timeout;
    } chk_rec_t;

    function automatic logic [Q_W-1:0] lfsr_next(input logic [Q_W-1:0] q);
        return {q[Q_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/obc_challenge_sequencer_if.sv
// Question channel to the OBC link, answer strobe back, and the record strobe
// to the checker. master = sequencer side.
interface obc_challenge_sequencer_if;
    import obc_chk_pkg::*;

    logic [Q_W-1:0] q_data;
    logic           q_valid;
    logic           q_ready;
    logic [Q_W-1:0] a_data;
    logic           a_valid;
    logic [Q_W-1:0] chk_question;
    logic [Q_W-1:0] chk_answer;
    logic           chk_timeout;
    logic           chk_valid;

    modport master (
        output q_data, q_valid, chk_question, chk_answer, chk_timeout, chk_valid,
        input  q_ready, a_data, a_valid
    );

    modport slave (
        input  q_data, q_valid, chk_question, chk_answer, chk_timeout, chk_valid,
        output q_ready, a_data, a_valid
    );

endinterface

// File: rtl/chal_lfsr.sv
// Challenge generator: 4-bit Fibonacci LFSR, steps once per accepted question.
module chal_lfsr
    import obc_chk_pkg::*;
#(
    parameter logic [Q_W-1:0] SEED = 4'h9
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           adv,
    output logic [Q_W-1:0] value
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    value <= SEED;
        else if (adv) value <= lfsr_next(value);
    end

endmodule

// File: rtl/obc_challenge_sequencer.sv
// Paced challenge/answer exchange with the OBC link; one record per challenge.
// Optional CHAL_STRAY_CNT_EN adds a saturating count of out-of-window answers.
module obc_challenge_sequencer
    import obc_chk_pkg::*;
#(
    parameter int              PERIOD_CYCLES  = 1000,
    parameter int              TIMEOUT_CYCLES = 500,
    parameter logic [Q_W-1:0]  LFSR_SEED      = 4'h9
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic busy,
`ifdef CHAL_STRAY_CNT_EN
    output logic [7:0] stray_cnt,
`endif
    obc_challenge_sequencer_if.master bus
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int GAP_W = $clog2(PERIOD_CYCLES) + 1;

    chal_state_t     state, state_nxt;
    logic [TO_W-1:0]  to_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [Q_W-1:0]   lfsr;
    logic [Q_W-1:0]   q_hold;
    chk_rec_t         rec;
    logic             hs;
    logic             rec_load;

    chal_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .adv   (hs),
        .value (lfsr)
    );

    assign hs       = (state == ST_SEND) && bus.q_ready;
    assign rec_load = (state == ST_WAIT_ANS) && (state_nxt == ST_REPORT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (enable) state_nxt = ST_SEND;
            ST_SEND:     if (bus.q_ready) state_nxt = ST_WAIT_ANS;
            // an answer in the expiry cycle still counts as answered
            ST_WAIT_ANS: if (bus.a_valid || to_cnt == TO_W'(TIMEOUT_CYCLES))
                             state_nxt = ST_REPORT;
            ST_REPORT:   state_nxt = enable ? ST_GAP : ST_IDLE;
            ST_GAP: begin
                if (!enable)                                state_nxt = ST_IDLE;
                else if (gap_cnt == GAP_W'(PERIOD_CYCLES - 1)) state_nxt = ST_SEND;
            end
            default:     state_nxt = ST_IDLE;
        endcase
    end

    // to_cnt holds the WAIT_ANS cycle number (1..TIMEOUT_CYCLES); both counters
    // restart from zero on every entry so they never need to wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt  <= '0;
            gap_cnt <= '0;
        end else begin
            if (hs)
                to_cnt <= TO_W'(1);
            else if (state == ST_WAIT_ANS && state_nxt == ST_WAIT_ANS)
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;

            if (state == ST_GAP && state_nxt == ST_GAP)
                gap_cnt <= gap_cnt + 1'b1;
            else
                gap_cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_hold <= '0;
            rec    <= '0;
        end else begin
            if (hs) q_hold <= lfsr;
            if (rec_load) begin
                rec.question <= q_hold;
                rec.answer   <= bus.a_valid ? bus.a_data : '0;
                rec.timeout  <= !bus.a_valid;
            end
        end
    end

`ifdef CHAL_STRAY_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stray_cnt <= '0;
        else if (bus.a_valid && state != ST_WAIT_ANS && stray_cnt != 8'hFF)
            stray_cnt <= stray_cnt + 8'd1;
    end
`endif

    assign bus.q_valid      = (state == ST_SEND);
    assign bus.q_data       = lfsr;
    assign bus.chk_valid    = (state == ST_REPORT);
    assign bus.chk_question = rec.question;
    assign bus.chk_answer   = rec.answer;
    assign bus.chk_timeout  = rec.timeout;
    assign busy             = (state != ST_IDLE);

endmodule

// File: tb/tb_obc_challenge_sequencer.sv
// Directed bench for obc_challenge_sequencer; expected records go through a
// scoreboard queue and are popped when chk_valid fires.
module tb_obc_challenge_sequencer;
    import obc_chk_pkg::*;

    localparam int PERIOD  = 8;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic busy;
`ifdef CHAL_STRAY_CNT_EN
    logic [7:0] stray_cnt;
`endif

    int checks = 0;
    int failures = 0;
    chk_rec_t sb[$];
    logic [Q_W-1:0] model;
    logic [Q_W-1:0] exp_seq [4];

    obc_challenge_sequencer_if bus();

    obc_challenge_sequencer #(
        .PERIOD_CYCLES  (PERIOD),
        .TIMEOUT_CYCLES (TIMEOUT),
        .LFSR_SEED      (4'h9)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .busy      (busy),
`ifdef CHAL_STRAY_CNT_EN
        .stray_cnt (stray_cnt),
`endif
        .bus       (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [Q_W-1:0] model_next(input logic [Q_W-1:0] q);
        return {q[2:0], q[3] ^ q[2]};
    endfunction

    task automatic push_exp(input logic [Q_W-1:0] q, input logic [Q_W-1:0] a, input logic t);
        chk_rec_t e;
        e.question = q;
        e.answer   = a;
        e.timeout  = t;
        sb.push_back(e);
    endtask

    task automatic wait_q(output logic [Q_W-1:0] q, output int n);
        n = 0;
        while (bus.q_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("q_valid_seen", {31'd0, bus.q_valid}, 32'd1);
        q = bus.q_data;
    endtask

    // Called in the cycle an answer is driven (or the handshake cycle for a
    // timeout); counts cycles until chk_valid and compares the popped record.
    task automatic wait_report(input string tag, input int exp_lat);
        int lat;
        chk_rec_t e;
        lat = 0;
        do begin
            tick();
            bus.a_valid = 1'b0;
            lat++;
        end while (bus.chk_valid !== 1'b1 && lat < 40);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_sb"}, sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_question"}, bus.chk_question, e.question);
            check({tag, "_answer"},   bus.chk_answer,   e.answer);
            check({tag, "_timeout"},  bus.chk_timeout,  e.timeout);
        end
    endtask

    // delay > TIMEOUT means the OBC never answers.
    task automatic challenge(input string tag, input int delay, input logic [Q_W-1:0] ans,
                             input logic [Q_W-1:0] exp_q, output int n);
        logic [Q_W-1:0] q;
        wait_q(q, n);
        check({tag, "_q"}, q, exp_q);
        if (delay > TIMEOUT) begin
            push_exp(exp_q, '0, 1'b1);
            wait_report(tag, TIMEOUT + 1);
        end else begin
            repeat (delay) tick();
            bus.a_valid = 1'b1;
            bus.a_data  = ans;
            push_exp(exp_q, ans, 1'b0);
            wait_report(tag, 1);
        end
        model = model_next(model);
    endtask

    initial begin
        logic [Q_W-1:0] q;
        int n;
        int bad;

        exp_seq[0] = 4'h9; exp_seq[1] = 4'h3; exp_seq[2] = 4'h6; exp_seq[3] = 4'hD;
        bus.q_ready = 1'b1;
        bus.a_valid = 1'b0;
        bus.a_data  = '0;
        model = 4'h9;

        tick(); tick();
        check("rst_q_valid",      bus.q_valid,      0);
        check("rst_q_data",       bus.q_data,       4'h9);
        check("rst_chk_valid",    bus.chk_valid,    0);
        check("rst_chk_timeout",  bus.chk_timeout,  0);
        check("rst_chk_question", bus.chk_question, 0);
        check("rst_chk_answer",   bus.chk_answer,   0);
        check("rst_busy",         busy,             0);

        reset = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 4; i++)
            challenge($sformatf("seq%0d", i), 1, 4'(i + 5), exp_seq[i], n);
        check("seq_busy_in_gap", busy, 1);

        challenge("tmo", TIMEOUT + 10, '0, model, n);
        challenge("edge4", TIMEOUT, 4'h7, model, n);
        check("gap_after_tmo", n, PERIOD + 1);
        tick(); tick();
        check("hold_answer", bus.chk_answer, 4'h7);
        check("hold_valid",  bus.chk_valid,  0);

        // enable dropped while waiting for the answer
        wait_q(q, n);
        check("drop_q", q, model);
        tick();
        enable = 1'b0;
        tick();
        bus.a_valid = 1'b1;
        bus.a_data  = 4'h2;
        push_exp(model, 4'h2, 1'b0);
        wait_report("drop", 1);
        model = model_next(model);
        tick();
        check("drop_busy", busy, 0);
        repeat (3) tick();
        check("drop_idle_q_valid", bus.q_valid, 0);

        // link stalls q_ready for 20 cycles right after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model = 4'h9;
        bus.q_ready = 1'b0;
        enable = 1'b1;
        wait_q(q, n);
        bad = 0;
        repeat (20) begin
            tick();
            if ({bus.q_valid, bus.q_data} !== 5'h19) bad++;
        end
        check("stall_stable", bad, 0);
        bus.q_ready = 1'b1;
        tick();
        bus.a_valid = 1'b1;
        bus.a_data  = 4'hC;
        push_exp(4'h9, 4'hC, 1'b0);
        wait_report("stall", 1);
        model = model_next(model);
        challenge("post_stall", 1, 4'h1, 4'h3, n);

        // reset in the middle of WAIT_ANS
        wait_q(q, n);
        tick();
        reset = 1'b1;
        bus.a_valid = 1'b1;
        #1;
        check("rst_mid_busy",   busy,       0);
        check("rst_mid_q_data", bus.q_data, 4'h9);
        bad = 0;
        repeat (4) begin
            tick();
            if (bus.chk_valid !== 1'b0) bad++;
        end
        reset = 1'b0;
        bus.a_valid = 1'b0;
        model = 4'h9;
        wait_q(q, n);
        check("rst_mid_no_chk", bad, 0);
        check("rst_mid_first_q", q, 4'h9);
        enable = 1'b0;
        tick(); tick(); tick();
        check("sb_drained", sb.size(), 0);

`ifdef CHAL_STRAY_CNT_EN
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("stray_rst", stray_cnt, 0);
        model = 4'h9;
        enable = 1'b1;
        challenge("stray_pre", 1, 4'h5, 4'h9, n);
        bad = 0;
        repeat (3) begin
            tick();
            bus.a_valid = 1'b1;
            tick();
            bus.a_valid = 1'b0;
            if (bus.chk_valid !== 1'b0) bad++;
        end
        check("stray_3", stray_cnt, 3);
        check("stray_no_chk", bad, 0);
        enable = 1'b0;
        tick();
        bus.a_valid = 1'b1;
        repeat (300) tick();
        bus.a_valid = 1'b0;
        tick();
        check("stray_sat", stray_cnt, 255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
